// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg: shared definitions for the LED chaser.
//   - MODE_* : pattern select codes carried on mode / active_mode.
//   - DIR_*  : bounce direction flag encoding.
//   - start_value(): first LED value shown after a mode is (re)selected.
package led_chaser_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROL    = 2'd0;
  localparam mode_t MODE_ROR    = 2'd1;
  localparam mode_t MODE_BOUNCE = 2'd2;
  localparam mode_t MODE_FILL   = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest LED bank the start-value helper can describe.
  localparam int LED_MAX_W = 64;

  // Start value of a pattern: only ROR begins at the MSB, all others at bit 0.
  function automatic logic [LED_MAX_W-1:0] start_value(input mode_t mode, input int width);
    logic [LED_MAX_W-1:0] v;
    case (mode)
      MODE_ROR: v = LED_MAX_W'(1) << (width - 1);
      MODE_ROL,
      MODE_BOUNCE,
      MODE_FILL: v = LED_MAX_W'(1);
      default:  v = LED_MAX_W'(1);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_chaser_tick_divider.sv
// tick_divider: prescaler producing one step tick every PRESCALE enabled cycles.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : count enable; low freezes the counter
//   clr   : synchronous clear of the counter (wins over en)
//   tick  : high in the cycle whose rising edge completes a step period
module tick_divider #(
  parameter int PRESCALE   = 3,
  parameter int PRESCALE_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] CNT_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] CNT_ZERO = PRESCALE_W'(0);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  // Tick is a pure decode of the counter; the consumer registers its effect.
  assign tick = en && (cnt_q == CNT_LAST);

  // Next-count logic: clear, wrap at the last count, or advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// led_chaser: programmable-rate LED pattern generator.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   en          : count enable; low freezes prescaler and pattern
//   clr         : synchronous clear; restarts prescaler and pattern in `mode`
//   mode        : requested pattern (ROL, ROR, BOUNCE, FILL)
//   led         : LED drive, bit 0 = rightmost LED
//   step        : one-cycle pulse when led shows a new value
//   wrap        : one-cycle pulse when the pattern returns to its start value
//   active_mode : pattern currently being generated
// A new mode request is only adopted on a step tick, so led never shows a
// partially updated value. All outputs come straight from flops.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int LED_WIDTH = 8,
  parameter int PRESCALE  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [1:0]           mode,
  output logic [LED_WIDTH-1:0] led,
  output logic                 step,
  output logic                 wrap,
  output logic [1:0]           active_mode
);

  localparam int PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [LED_WIDTH-1:0] LED_ZERO = {LED_WIDTH{1'b0}};
  localparam logic [LED_WIDTH-1:0] LED_ONE  = {{(LED_WIDTH-1){1'b0}}, 1'b1};

  logic                 tick_s;
  logic [LED_WIDTH-1:0] led_q,  led_d;
  logic                 dir_q,  dir_d;
  mode_t                mode_q, mode_d;
  logic                 step_q, step_d;
  logic                 wrap_q, wrap_d;

  tick_divider #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .tick  (tick_s)
  );

  // Pattern next-state: clear beats tick; a tick either switches mode or advances.
  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (clr) begin
      mode_d = mode;
      led_d  = LED_WIDTH'(start_value(mode, LED_WIDTH));
      dir_d  = DIR_UP;
    end else if (tick_s) begin
      step_d = 1'b1;
      if (mode != mode_q) begin
        // Switching restarts the new pattern; this step never counts as a wrap.
        mode_d = mode;
        led_d  = LED_WIDTH'(start_value(mode, LED_WIDTH));
        dir_d  = DIR_UP;
      end else begin
        case (mode_q)
          MODE_ROL: begin
            led_d  = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
            wrap_d = led_q[LED_WIDTH-1];
          end
          MODE_ROR: begin
            led_d  = {led_q[0], led_q[LED_WIDTH-1:1]};
            wrap_d = led_q[0];
          end
          MODE_BOUNCE: begin
            // Direction flips on arrival at an end so no end value is shown twice.
            if (dir_q == DIR_UP) begin
              led_d = {led_q[LED_WIDTH-2:0], 1'b0};
              if (led_q[LED_WIDTH-2]) begin
                dir_d = DIR_DOWN;
              end else begin
                dir_d = DIR_UP;
              end
            end else begin
              led_d = {1'b0, led_q[LED_WIDTH-1:1]};
              if (led_q[1]) begin
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                dir_d  = DIR_DOWN;
              end
            end
          end
          MODE_FILL: begin
            // Thermometer fills up, drops to all-off, then restarts at 1.
            if (&led_q) begin
              led_d = LED_ZERO;
            end else if (led_q == LED_ZERO) begin
              led_d  = LED_ONE;
              wrap_d = 1'b1;
            end else begin
              led_d = {led_q[LED_WIDTH-2:0], 1'b1};
            end
          end
          default: begin
            led_d = led_q;
          end
        endcase
      end
    end else begin
      led_d = led_q;
    end
  end

  // Pattern, direction, mode and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= LED_ONE;
      dir_q  <= DIR_UP;
      mode_q <= MODE_ROL;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign led         = led_q;
  assign step        = step_q;
  assign wrap        = wrap_q;
  assign active_mode = mode_q;

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: two chasers (8 LEDs / divide-by-3 and 4 LEDs / divide-by-1)
// driven by directed scenarios followed by random enable, clear, mode and reset
// activity. The reference model tracks each chaser as a position index within
// the selected pattern's sequence and derives the LED value arithmetically.
module tb_led_chaser;

  localparam int W0 = 8;
  localparam int P0 = 3;
  localparam int W1 = 4;
  localparam int P1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en_i [2];
  logic clr_i [2];
  logic [1:0] mode_i [2];

  logic [W0-1:0] led0;
  logic [W1-1:0] led1;
  logic step0, step1, wrap0, wrap1;
  logic [1:0] am0, am1;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per chaser.
  int   m_cnt [2];
  int   m_mode [2];
  int   m_idx [2];
  logic m_step [2];
  logic m_wrap [2];

  led_chaser #(.LED_WIDTH(W0), .PRESCALE(P0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_i[0]), .clr(clr_i[0]), .mode(mode_i[0]),
    .led(led0), .step(step0), .wrap(wrap0), .active_mode(am0)
  );

  led_chaser #(.LED_WIDTH(W1), .PRESCALE(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_i[1]), .clr(clr_i[1]), .mode(mode_i[1]),
    .led(led1), .step(step1), .wrap(wrap1), .active_mode(am1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int prescale_of(input int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic int period_of(input int mode, input int w);
    case (mode)
      0, 1:    return w;
      2:       return 2 * w - 2;
      default: return w + 1;
    endcase
  endfunction

  // LED value at position idx of a pattern's sequence.
  function automatic logic [31:0] seq_val(input int mode, input int w, input int idx);
    case (mode)
      0:       return 32'd1 << idx;
      1:       return 32'd1 << (w - 1 - idx);
      2:       return (idx < w) ? (32'd1 << idx) : (32'd1 << (2 * w - 2 - idx));
      default: return (idx < w) ? ((32'd1 << (idx + 1)) - 32'd1) : 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_mode[d] = 0; m_idx[d] = 0; m_step[d] = 1'b0; m_wrap[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    m_step[d] = 1'b0;
    m_wrap[d] = 1'b0;
    if (clr_i[d]) begin
      m_cnt[d] = 0; m_mode[d] = int'(mode_i[d]); m_idx[d] = 0;
    end else if (en_i[d]) begin
      if (m_cnt[d] == prescale_of(d) - 1) begin
        m_cnt[d] = 0;
        m_step[d] = 1'b1;
        if (int'(mode_i[d]) != m_mode[d]) begin
          m_mode[d] = int'(mode_i[d]);
          m_idx[d] = 0;
        end else begin
          m_idx[d] = (m_idx[d] + 1) % period_of(m_mode[d], width_of(d));
          m_wrap[d] = (m_idx[d] == 0);
        end
      end else begin
        m_cnt[d]++;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("led0",  32'(led0),  seq_val(m_mode[0], W0, m_idx[0]));
    check_eq("step0", 32'(step0), 32'(m_step[0]));
    check_eq("wrap0", 32'(wrap0), 32'(m_wrap[0]));
    check_eq("mode0", 32'(am0),   32'(m_mode[0]));
    check_eq("led1",  32'(led1),  seq_val(m_mode[1], W1, m_idx[1]));
    check_eq("step1", 32'(step1), 32'(m_step[1]));
    check_eq("wrap1", 32'(wrap1), 32'(m_wrap[1]));
    check_eq("mode1", 32'(am1),   32'(m_mode[1]));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        model_step(0);
        model_step(1);
      end
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en_i[d] = 1'b0; clr_i[d] = 1'b0; mode_i[d] = 2'd0;
    end
    model_reset();
    cycle(3);
    rst_n = 1'b1;

    // ROL on dut0 (step every 3rd cycle), BOUNCE on dut1 (every cycle).
    en_i[0] = 1'b1; mode_i[0] = 2'd0;
    en_i[1] = 1'b1; mode_i[1] = 2'd2;
    cycle(12);
    check_eq("rol_at_12", 32'(led0), 32'h10);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_led",  32'(led0), 32'h01);
    check_eq("async_step", 32'(step0), 32'h0);
    check_eq("async_wrap", 32'(wrap0), 32'h0);
    check_eq("async_mode", 32'(am1), 32'h0);
    model_reset();
    @(negedge clk);
    cycle(2);
    rst_n = 1'b1;

    // Mode change two cycles before a tick while ROL sits at 0x08; FILL on dut1.
    mode_i[1] = 2'd3;
    cycle(10);
    mode_i[0] = 2'd1;
    cycle(1);
    check_eq("hold_08", 32'(led0), 32'h08);
    cycle(1);
    check_eq("switch_led",  32'(led0), 32'h80);
    check_eq("switch_mode", 32'(am0), 32'h1);
    check_eq("switch_step", 32'(step0), 32'h1);
    check_eq("switch_wrap", 32'(wrap0), 32'h0);

    // Freeze at cnt=1 for 10 cycles; the tick then needs 2 more enabled cycles.
    cycle(1);
    en_i[0] = 1'b0;
    cycle(10);
    en_i[0] = 1'b1;
    cycle(1);
    check_eq("resume_nostep", 32'(step0), 32'h0);
    cycle(1);
    check_eq("resume_step", 32'(step0), 32'h1);
    check_eq("resume_led",  32'(led0), 32'h40);

    // Clear coincident with a tick.
    cycle(2);
    clr_i[0] = 1'b1; mode_i[0] = 2'd0;
    cycle(1);
    clr_i[0] = 1'b0;
    check_eq("clr_led",  32'(led0), 32'h01);
    check_eq("clr_step", 32'(step0), 32'h0);

    // Random phase.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom % 400) != 0;
      for (int d = 0; d < 2; d++) begin
        if (($urandom % 16) == 0) mode_i[d] = 2'($urandom % 4);
        en_i[d]  = ($urandom % 8) != 0;
        clr_i[d] = ($urandom % 40) == 0;
      end
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
